fn_sweep_ctrl: RTL and testbench
================================

Name: fn_sweep_ctrl

Overview:
- Sequencer for the 4-input logic cell f(a,b,c,d) = ((a & b) | d) ^ (b & c).
- Owns one internal instance of the cell and drives all 16 input vectors into it in order.
- Captures the 16-bit truth table, compares it against a golden signature and reports busy/done/pass on the standard 8-in/8-out tile pins.
- Supports free-running and single-step sequencing, plus fault injection to exercise the fail path.

Parameters:
- EXPECTED, 16'h3F48, golden truth table; bit i = f at vector index i.
- SETTLE, 2, cycles (or steps) each vector is held before sampling; legal range 1..15.
- INJ_IDX, 5, vector index whose sample is inverted when inject is high.

Ports:
- io_in[0]  input  1  clk; the single clock, rising edge.
- io_in[1]  input  1  rst; asynchronous, active-high reset.
- io_in[2]  input  1  start; a rising edge launches a sweep.
- io_in[3]  input  1  inject; inverts the sample at INJ_IDX.
- io_in[5:4]  input  2  nib_sel; selects the truth-table nibble shown on readout.
- io_in[6]  input  1  step_mode; 1 = advance only on step edges.
- io_in[7]  input  1  step; a rising edge is one step.
- io_out[0]  output  1  busy.
- io_out[1]  output  1  done.
- io_out[2]  output  1  pass; meaningful only while done = 1.
- io_out[3]  output  1  live cell output f for the current vector.
- io_out[7:4]  output  4  vector index while busy; otherwise cap[4*nib_sel +: 4].

Behaviour:
- Vector mapping: a = idx[0], b = idx[1], c = idx[2], d = idx[3].
- Reset (asynchronous, active-high):
  - state = IDLE; idx = 0; settle counter = 0; cap = 16'h0; pass register = 0.
  - Edge-detect registers for start and step reset to 1, so a level held high across reset release does not trigger.
  - Resulting outputs: io_out[2:0] = 0, io_out[7:4] = 0, io_out[3] = f(0) = 0.
- Edge detect: pulse = in & ~prev, with prev registered every clk. No synchroniser is required; inputs are clk-synchronous.
- States:
  - IDLE: busy = 0, done = 0. A start pulse moves to RUN, clears cap, sets idx = 0 and settle = 0.
  - RUN: busy = 1.
    - Advance condition: every cycle when step_mode = 0; only on a step pulse when step_mode = 1.
    - On each advance, settle increments. When settle reaches SETTLE-1 and advances, sample: cap[idx] <= f ^ (inject && idx == INJ_IDX).
    - After a sample: settle = 0; if idx == 15, go to DONE, else idx++.
  - DONE: done = 1; pass = (cap == EXPECTED), registered on the DONE entry cycle. A start pulse behaves as in IDLE (restart).
- Latency, free-running: start pulse at edge N puts RUN in effect from N+1. The last sample is taken at edge N+16*SETTLE and done rises at that same edge. Total busy cycles = 16*SETTLE.
- Start pulse during RUN: ignored, no restart.
- step_mode toggled mid-RUN: takes effect on the next cycle. Step pulses in free-running mode are ignored.
- idx never wraps inside a sweep; 15 is terminal.
- inject is sampled only at INJ_IDX's sample cycle; toggling it at any other time has no effect.
- Reset mid-RUN: immediate return to reset values; the partial cap is discarded.
- nib_sel is combinational to io_out[7:4] outside busy.
- io_out[3] is always the combinational cell output for the current idx.

Decomposition:
- Shared package (fn_sweep_pkg):
  - state enum {IDLE, RUN, DONE}.
  - Golden constant FN_TT = 16'h3F48.
  - Pin index constants for io_in/io_out.
- One sub-module, fn_cell: the combinational f(a,b,c,d), built from the existing and_cell / or_cell / xor_cell primitives. It is instantiated once, driven by idx.

Test Plan:
- Reset, then start pulse, step_mode = 0, SETTLE = 2: busy = 1 for exactly 32 cycles. Then done = 1, pass = 1, and nib_sel 0..3 reads 8, 4, F, 3.
- inject = 1 for the whole sweep: done with pass = 0; nib_sel = 1 reads 4'h6 (bit 5 set); the other nibbles are unchanged.
- step_mode = 1, 31 step pulses: still busy, io_out[7:4] = 15. The 32nd step pulse gives done = 1, pass = 1. Clocks without steps do not advance.
- Start pulse while busy at idx = 7: no restart, and done arrives at the original cycle. A start pulse in DONE restarts, with cap cleared (nib readout 0 at the first busy-exit check).
- Reset asserted at idx = 9 mid-sweep: outputs go to 0 asynchronously. With start held high through reset release, no sweep begins until start goes low then high.
- While busy, io_out[3] matches f(idx) for every idx 0..15 (expected sequence 0,0,0,1,0,0,1,0,1,1,1,1,1,1,0,0).

Source files
------------

// File: rtl/fn_sweep_pkg.sv
// Shared definitions for the fn_sweep_ctrl slice.
// Holds the sequencer state enum, the golden truth table of
// f(a,b,c,d) = ((a & b) | d) ^ (b & c), and the tile pin indices.
package fn_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Bit i is f at vector index i, where a = i[0], b = i[1], c = i[2], d = i[3].
   localparam logic [15:0] FN_TT = 16'h3F48;

   // io_in pin map
   localparam int unsigned IN_CLK       = 0;
   localparam int unsigned IN_RST       = 1;
   localparam int unsigned IN_START     = 2;
   localparam int unsigned IN_INJECT    = 3;
   localparam int unsigned IN_NIB_LO    = 4;
   localparam int unsigned IN_STEP_MODE = 6;
   localparam int unsigned IN_STEP      = 7;

   // io_out pin map
   localparam int unsigned OUT_BUSY   = 0;
   localparam int unsigned OUT_DONE   = 1;
   localparam int unsigned OUT_PASS   = 2;
   localparam int unsigned OUT_F      = 3;
   localparam int unsigned OUT_NIB_LO = 4;

endpackage

// File: rtl/fn_sweep_ctrl_if.sv
// Tile pin bundle for fn_sweep_ctrl (everything except clk/rst).
//   start, inject, nib_sel[1:0], step_mode, step : control inputs (io_in[7:2])
//   io_out[7:0]                                 : busy/done/pass/f/nibble outputs
interface fn_sweep_ctrl_if;

   logic       start;
   logic       inject;
   logic [1:0] nib_sel;
   logic       step_mode;
   logic       step;
   logic [7:0] io_out;

   modport master (
      output start,
      output inject,
      output nib_sel,
      output step_mode,
      output step,
      input  io_out
   );

   modport slave (
      input  start,
      input  inject,
      input  nib_sel,
      input  step_mode,
      input  step,
      output io_out
   );

endinterface

// File: rtl/and_cell.sv
// 2-input AND primitive.
//   i_a, i_b : operands
//   o_y      : i_a & i_b
module and_cell (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a & i_b;
endmodule

// File: rtl/fn_cell.sv
// Combinational logic cell f(a,b,c,d) = ((a & b) | d) ^ (b & c).
//   i_vec[3:0] : {d, c, b, a}
//   o_f        : cell output
module fn_cell (
   input  logic [3:0] i_vec,
   output logic       o_f
);

   logic w_ab;
   logic w_bc;
   logic w_abd;

   and_cell u_and_ab (.i_a(i_vec[0]), .i_b(i_vec[1]), .o_y(w_ab));
   and_cell u_and_bc (.i_a(i_vec[1]), .i_b(i_vec[2]), .o_y(w_bc));
   or_cell  u_or_abd (.i_a(w_ab),     .i_b(i_vec[3]), .o_y(w_abd));
   xor_cell u_xor_f  (.i_a(w_abd),    .i_b(w_bc),     .o_y(o_f));

endmodule

// File: rtl/or_cell.sv
// 2-input OR primitive.
//   i_a, i_b : operands
//   o_y      : i_a | i_b
module or_cell (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a | i_b;
endmodule

// File: rtl/xor_cell.sv
// 2-input XOR primitive.
//   i_a, i_b : operands
//   o_y      : i_a ^ i_b
module xor_cell (
   input  logic i_a,
   input  logic i_b,
   output logic o_y
);
   assign o_y = i_a ^ i_b;
endmodule

// File: rtl/fn_sweep_ctrl.sv
// Truth-table sweep sequencer for fn_cell.
// Walks all 16 input vectors through one fn_cell, holds each for SETTLE advances,
// captures the table, and compares it with EXPECTED on completion.
//   i_clk   : clock, rising edge
//   i_rst   : asynchronous active-high reset
//   io_pins : start/inject/nib_sel/step_mode/step in, io_out[7:0] out
//             io_out[0] busy, [1] done, [2] pass, [3] live f,
//             [7:4] idx while busy, else captured nibble nib_sel
module fn_sweep_ctrl
   import fn_sweep_pkg::*;
#(
   parameter logic [15:0] EXPECTED = FN_TT,
   parameter int unsigned SETTLE   = 2,
   parameter int unsigned INJ_IDX  = 5
) (
   input  logic           i_clk,
   input  logic           i_rst,
   fn_sweep_ctrl_if.slave io_pins
);

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [3:0] INJ_SEL     = 4'(INJ_IDX);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_idx;
   logic [3:0]  r_settle;
   logic [15:0] r_cap;
   logic        r_pass;
   logic        r_start_prev;
   logic        r_step_prev;

   logic        w_start_pulse;
   logic        w_step_pulse;
   logic        w_adv;
   logic        w_sample;
   logic        w_last;
   logic        w_f;
   logic        w_smp_bit;
   logic [15:0] w_cap_smp;
   logic        w_busy;
   logic        w_done;
   logic [3:0]  w_nib;

   fn_cell u_cell (
      .i_vec (r_idx),
      .o_f   (w_f)
   );

   assign w_start_pulse = io_pins.start & ~r_start_prev;
   assign w_step_pulse  = io_pins.step & ~r_step_prev;
   assign w_adv         = (r_state == RUN) && (io_pins.step_mode ? w_step_pulse : 1'b1);
   assign w_sample      = w_adv && (r_settle == SETTLE_LAST);
   assign w_last        = w_sample && (r_idx == 4'd15);
   assign w_smp_bit     = w_f ^ (io_pins.inject && (r_idx == INJ_SEL));

   always_comb begin
      w_cap_smp        = r_cap;
      w_cap_smp[r_idx] = w_smp_bit;
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; start is ignored while RUN
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_start_pulse) w_state_nxt = RUN;
         RUN:     if (w_last)        w_state_nxt = DONE;
         DONE:    if (w_start_pulse) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Sweep datapath
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx        <= 4'd0;
         r_settle     <= 4'd0;
         r_cap        <= 16'h0;
         r_pass       <= 1'b0;
         // Reset high so a level held across reset release is not seen as an edge
         r_start_prev <= 1'b1;
         r_step_prev  <= 1'b1;
      end else begin
         r_start_prev <= io_pins.start;
         r_step_prev  <= io_pins.step;
         if (w_start_pulse && (r_state != RUN)) begin
            r_idx    <= 4'd0;
            r_settle <= 4'd0;
            r_cap    <= 16'h0;
            r_pass   <= 1'b0;
         end else if (w_sample) begin
            r_cap    <= w_cap_smp;
            r_settle <= 4'd0;
            if (r_idx == 4'd15) begin
               r_pass <= (w_cap_smp == EXPECTED);
            end else begin
               r_idx <= r_idx + 4'd1;
            end
         end else if (w_adv) begin
            r_settle <= r_settle + 4'd1;
         end
      end
   end

   // Outputs
   always_comb begin
      w_busy = (r_state == RUN);
      w_done = (r_state == DONE);
      w_nib  = r_cap[{io_pins.nib_sel, 2'b00} +: 4];
      io_pins.io_out = {(w_busy ? r_idx : w_nib), w_f, (w_done & r_pass), w_done, w_busy};
   end

endmodule

// File: tb/tb_fn_sweep_ctrl.sv
// Directed self-checking bench for fn_sweep_ctrl (SETTLE = 2, INJ_IDX = 5).
module tb_fn_sweep_ctrl;
   import fn_sweep_pkg::*;

   logic r_clk = 1'b0;
   logic r_rst;
   int   n_cmp = 0;
   int   n_err = 0;

   // Hand-derived truth table of ((a&b)|d)^(b&c), bit i = f(i):
   // 0,0,0,1, 0,0,1,0, 1,1,1,1, 1,1,0,0
   logic [15:0] tt_exp = 16'b0011_1111_0100_1000;
   // Same table with bit 5 inverted
   logic [15:0] tt_inj = 16'b0011_1111_0110_1000;

   fn_sweep_ctrl_if u_if ();

   fn_sweep_ctrl #(
      .EXPECTED (16'h3F48),
      .SETTLE   (2),
      .INJ_IDX  (5)
   ) u_dut (
      .i_clk   (r_clk),
      .i_rst   (r_rst),
      .io_pins (u_if)
   );

   always #5 r_clk = ~r_clk;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clk_step(input int n);
      repeat (n) begin
         @(posedge r_clk);
         #1;
      end
   endtask

   task automatic start_pulse();
      u_if.start = 1'b1;
      clk_step(1);
      u_if.start = 1'b0;
   endtask

   task automatic step_pulse();
      u_if.step = 1'b1;
      clk_step(1);
      u_if.step = 1'b0;
      clk_step(1);
   endtask

   task automatic check_nibbles(input string tag, input logic [15:0] tt);
      for (int n = 0; n < 4; n++) begin
         u_if.nib_sel = 2'(n);
         #1;
         check_val($sformatf("%s_nib%0d", tag, n), 16'(u_if.io_out[7:4]), 16'(tt[4*n +: 4]));
      end
      u_if.nib_sel = 2'd0;
   endtask

   initial begin
      r_rst          = 1'b1;
      u_if.start     = 1'b0;
      u_if.inject    = 1'b0;
      u_if.nib_sel   = 2'd0;
      u_if.step_mode = 1'b0;
      u_if.step      = 1'b0;
      clk_step(2);
      check_val("reset_out", 16'(u_if.io_out), 16'h0);
      r_rst = 1'b0;
      clk_step(2);
      check_val("idle_out", 16'(u_if.io_out), 16'h0);

      // Free-running sweep: busy for exactly 32 cycles, f follows the table
      start_pulse();
      for (int k = 0; k < 32; k++) begin
         check_val($sformatf("run_busy_%0d", k), 16'(u_if.io_out[OUT_BUSY]), 16'd1);
         if (k % 2 == 0) begin
            check_val($sformatf("run_idx_%0d", k), 16'(u_if.io_out[7:4]), 16'(k / 2));
            check_val($sformatf("run_f_%0d", k / 2), 16'(u_if.io_out[OUT_F]),
                      16'(tt_exp[k / 2]));
         end
         clk_step(1);
      end
      check_val("run_end_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd0);
      check_val("run_end_done", 16'(u_if.io_out[OUT_DONE]), 16'd1);
      check_val("run_end_pass", 16'(u_if.io_out[OUT_PASS]), 16'd1);
      check_nibbles("run", tt_exp);

      // Fault injection across the whole sweep
      u_if.inject = 1'b1;
      start_pulse();
      clk_step(32);
      u_if.inject = 1'b0;
      check_val("inj_done", 16'(u_if.io_out[OUT_DONE]), 16'd1);
      check_val("inj_pass", 16'(u_if.io_out[OUT_PASS]), 16'd0);
      check_nibbles("inj", tt_inj);

      // Single-step mode
      u_if.step_mode = 1'b1;
      start_pulse();
      clk_step(5);
      check_val("step_hold_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd1);
      check_val("step_hold_idx", 16'(u_if.io_out[7:4]), 16'd0);
      repeat (3) step_pulse();
      check_val("step3_idx", 16'(u_if.io_out[7:4]), 16'd1);
      repeat (28) step_pulse();
      check_val("step31_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd1);
      check_val("step31_idx", 16'(u_if.io_out[7:4]), 16'd15);
      u_if.step = 1'b1;
      clk_step(1);
      u_if.step = 1'b0;
      check_val("step32_done", 16'(u_if.io_out[OUT_DONE]), 16'd1);
      check_val("step32_pass", 16'(u_if.io_out[OUT_PASS]), 16'd1);
      u_if.step_mode = 1'b0;
      clk_step(1);

      // Start while busy is ignored; completion time unchanged
      start_pulse();
      clk_step(14);
      check_val("restart_idx7", 16'(u_if.io_out[7:4]), 16'd7);
      start_pulse();
      check_val("restart_ign_idx", 16'(u_if.io_out[7:4]), 16'd7);
      clk_step(16);
      check_val("restart_ign_busy31", 16'(u_if.io_out[OUT_BUSY]), 16'd1);
      clk_step(1);
      check_val("restart_ign_done32", 16'(u_if.io_out[OUT_DONE]), 16'd1);
      check_val("restart_ign_pass", 16'(u_if.io_out[OUT_PASS]), 16'd1);

      // Start in DONE restarts
      start_pulse();
      check_val("redo_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd1);
      check_val("redo_idx", 16'(u_if.io_out[7:4]), 16'd0);
      check_val("redo_pass", 16'(u_if.io_out[OUT_PASS]), 16'd0);

      // Asynchronous reset at idx 9 with start held high through release
      clk_step(18);
      check_val("pre_rst_idx9", 16'(u_if.io_out[7:4]), 16'd9);
      u_if.start = 1'b1;
      r_rst = 1'b1;
      #1;
      check_val("async_rst_out", 16'(u_if.io_out), 16'h0);
      clk_step(2);
      r_rst = 1'b0;
      clk_step(3);
      check_val("held_start_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd0);
      check_val("held_start_nib", 16'(u_if.io_out[7:4]), 16'd0);
      u_if.start = 1'b0;
      clk_step(1);
      start_pulse();
      check_val("new_start_busy", 16'(u_if.io_out[OUT_BUSY]), 16'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
